key_interrupt_handler: RTL

Processor-side responder for the key interrupt raised by the input controller. It detects each rising edge of `key_interrupt` and stamps the event with the current game frame number. Events are queued in a small FIFO, and `irq` is held until the CPU acknowledges each event, one per `irq_ack`. Sits between the input controller and the CPU interrupt/MMIO logic on the single system clock.

---
 rtl/key_interrupt_handler.sv | 64 ++++++
 1 files changed

// File: rtl/key_interrupt_handler.sv
// key_interrupt_handler: detects key interrupt edges and queues each one with a frame
// stamp. irq stays high until every queued event has been acknowledged.
module key_interrupt_handler #(
    parameter int DEPTH   = 4,
    parameter int STAMP_W = 8,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               key_interrupt,
    input  logic               frame_rt_clk,
    input  logic               irq_ack,
    input  logic               overflow_clr,
    output logic               irq,
    output logic [STAMP_W-1:0] event_frame,
    output logic [PTR_W:0]     pending,
    output logic               overflow,
    output logic [STAMP_W-1:0] frame_count
);
    localparam logic [PTR_W:0]     full_cnt  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]     cnt_one   = 1;
    localparam logic [PTR_W-1:0]   ptr_one   = 1;
    localparam logic [STAMP_W-1:0] stamp_one = 1;
    logic [STAMP_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic               key_prev, frame_prev;
    logic               key_evt, frame_tick, pop, push, drop;
    always_comb begin
        key_evt    = key_interrupt & ~key_prev;
        frame_tick = frame_rt_clk & ~frame_prev;
        pop        = irq_ack & (pending != '0);
        // a pop on the same edge frees the slot, so a full queue still accepts the push
        push       = key_evt & ((pending != full_cnt) | pop);
        drop       = key_evt & ~push;
    end
    always_ff @(posedge sysclk) begin
        if (reset) begin
            key_prev    <= 1'b0;
            frame_prev  <= 1'b0;
            frame_count <= '0;
            head        <= '0;
            tail        <= '0;
            pending     <= '0;
            overflow    <= 1'b0;
        end else begin
            key_prev    <= key_interrupt;
            frame_prev  <= frame_rt_clk;
            frame_count <= frame_tick ? frame_count + stamp_one : frame_count;
            head        <= pop ? head + ptr_one : head;
            tail        <= push ? tail + ptr_one : tail;
            pending     <= (push & ~pop) ? pending + cnt_one :
                           (pop & ~push) ? pending - cnt_one : pending;
            overflow    <= drop ? 1'b1 : overflow_clr ? 1'b0 : overflow;
        end
    end
    // storage is left uncleared by reset; occupancy alone decides validity
    always_ff @(posedge sysclk) begin
        if (!reset && push) mem[tail] <= frame_count;
    end
    always_comb begin
        irq         = pending != '0;
        event_frame = irq ? mem[head] : '0;
    end
endmodule
